// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane mask helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Little-endian lanes touched by a transfer; sizes above a doubleword saturate at 8 lanes.
    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] m;
        int         n;
        n = (size > 3'd3) ? 8 : (1 << size);
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i >= int'(off)) && (i < int'(off) + n);
        end
        return m;
    endfunction

endpackage

// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite bus bundle between one master-side driver and the RAM slave.
interface ahb_ram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata,
        input  hready, hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_ram_mem.sv
// Word-organised RAM array with per-byte write strobes and an asynchronous read tap.
module ahb_ram_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    localparam int unsigned NB        = DATA_WIDTH / 8,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [NB-1:0]         wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM slave: pipelined address/data phase, byte-lane writes, optional wait states.
// Define AHB_RAM_ERR_CHECK_EN to flag out-of-range, misaligned and oversize transfers as ERROR.
module ahb_ram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic            clk,
    input logic            rst,
    ahb_ram_slave_if.slave bus
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [IW-1:0]         dp_word_q;
    logic [NB-1:0]         dp_lanes_q;
    logic                  dp_write_q;
    logic                  dp_err_q;

    logic                  accept;
    logic                  advance;
    logic                  commit;
    logic                  a_err;
    logic [IW-1:0]         a_word;
    logic [LB-1:0]         a_off_raw;
    logic [LB-1:0]         a_off;
    logic [LB-1:0]         size_lo;
    logic [7:0]            mask_full;
    logic                  unused_mask;
    logic [NB-1:0]         a_lanes;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] rd_next;

    assign a_word    = bus.haddr[IW+LB-1:LB];
    assign a_off_raw = bus.haddr[LB-1:0];
    assign size_lo   = ~({LB{1'b1}} << bus.hsize);

`ifdef AHB_RAM_ERR_CHECK_EN
    localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;
    logic [ADDR_WIDTH-1:0] a_index;

    assign a_index = bus.haddr >> LB;
    assign a_off   = a_off_raw;
    assign a_err   = (a_index >= ADDR_WIDTH'(DEPTH)) | (|(a_off_raw & size_lo)) |
                     (bus.hsize > MAX_SIZE);
`else
    logic unused_haddr;

    // Upper address bits are ignored so the word index wraps modulo DEPTH.
    assign unused_haddr = ^bus.haddr;
    assign a_off        = a_off_raw & ~size_lo;
    assign a_err        = 1'b0;
`endif

    assign mask_full   = lane_mask(bus.hsize, 3'(a_off));
    assign a_lanes     = mask_full[NB-1:0];
    assign unused_mask = ^mask_full;

    assign accept  = bus.hsel & bus.htrans[1] & bus.hready;
    assign advance = bus.hready & ((state_q == ST_IDLE) | (state_q == ST_ERR2) |
                                   ((state_q == ST_DATA) & (cnt_q == 4'd0)));
    assign commit  = advance & (state_q == ST_DATA) & dp_write_q & ~dp_err_q;

    ahb_ram_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (commit),
        .waddr(dp_word_q),
        .wstrb(dp_lanes_q),
        .wdata(bus.hwdata),
        .raddr(a_word),
        .rdata(ram_rdata)
    );

    // A read accepted on the same edge a write to that word commits sees the new bytes.
    always_comb begin
        rd_next = ram_rdata;
        for (int i = 0; i < NB; i++) begin
            if (commit && (dp_word_q == a_word) && dp_lanes_q[i]) begin
                rd_next[8*i +: 8] = bus.hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            dp_word_q   <= '0;
            dp_lanes_q  <= '0;
            dp_write_q  <= 1'b0;
            dp_err_q    <= 1'b0;
        end else if (state_q == ST_ERR1) begin
            state_q     <= ST_ERR2;
            hreadyout_q <= 1'b1;
        end else if ((state_q == ST_DATA) && (cnt_q != 4'd0)) begin
            cnt_q       <= cnt_q - 4'd1;
            hreadyout_q <= (cnt_q == 4'd1);
        end else if (advance) begin
            if (accept) begin
                dp_word_q  <= a_word;
                dp_lanes_q <= a_lanes;
                dp_write_q <= bus.hwrite;
                dp_err_q   <= a_err;
                if (a_err) begin
                    state_q     <= ST_ERR1;
                    hreadyout_q <= 1'b0;
                    hresp_q     <= HRESP_ERROR;
                end else begin
                    state_q     <= ST_DATA;
                    cnt_q       <= 4'(WAIT_STATES);
                    hreadyout_q <= (WAIT_STATES == 0);
                    hresp_q     <= HRESP_OKAY;
                    if (!bus.hwrite) begin
                        hrdata_q <= rd_next;
                    end
                end
            end else begin
                state_q     <= ST_IDLE;
                hreadyout_q <= 1'b1;
                hresp_q     <= HRESP_OKAY;
            end
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave: zero-wait and 3-wait instances on one clock.
module tb_ahb_ram_slave;
    import ahb_pkg::*;

    localparam int unsigned DEPTH = 256;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic hold0 = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    ahb_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    ahb_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

    // hold0 models another slave stretching the bus on the zero-wait instance.
    assign if0.hready = if0.hreadyout & ~hold0;
    assign if3.hready = if3.hreadyout;

    ahb_ram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)
    ) u0 (
        .clk(clk), .rst(rst), .bus(if0)
    );

    ahb_ram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)
    ) u3 (
        .clk(clk), .rst(rst), .bus(if3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr);
        if0.hsel   = sel;
        if0.htrans = trans;
        if0.hwrite = wr;
        if0.hsize  = size;
        if0.haddr  = addr;
    endtask

    task automatic req3(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr);
        if3.hsel   = sel;
        if3.htrans = trans;
        if3.hwrite = wr;
        if3.hsize  = size;
        if3.haddr  = addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        req0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        req3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        if0.hwdata = '0;
        if3.hwdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hreadyout", 32'(if0.hreadyout), 32'h1);
        chk("rst_hresp", 32'(if0.hresp), 32'h0);
        chk("rst_hrdata", if0.hrdata, 32'h0);
        chk("rst_hreadyout_ws3", 32'(if3.hreadyout), 32'h1);
        rst = 1'b0;
        tick();

        // Back-to-back word write then read of the same address.
        req0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
        tick();
        chk("b2b_wr_ready", 32'(if0.hreadyout), 32'h1);
        if0.hwdata = 32'hDEADBEEF;
        req0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        tick();
        chk("b2b_rd_ready", 32'(if0.hreadyout), 32'h1);
        chk("b2b_rd_data", if0.hrdata, 32'hDEADBEEF);
        req0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        tick();

        // Byte and halfword lane writes over a known word.
        req0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
        tick();
        if0.hwdata = 32'h11223344;
        req0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13);
        tick();
        if0.hwdata = 32'hAAAAAAAA;
        req0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        tick();
        chk("byte_lane", if0.hrdata, 32'hAA223344);
        req0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h12);
        tick();
        if0.hwdata = 32'h55665566;
        req0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        tick();
        chk("half_lane", if0.hrdata, 32'h55663344);
        chk("half_lane_resp", 32'(if0.hresp), 32'h0);

        // Seed word 0 so later reads show a distinct value.
        req0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0);
        tick();
        if0.hwdata = 32'hCAFEF00D;
        req0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        chk("word0_init", if0.hrdata, 32'hCAFEF00D);

        // BUSY, deselected and stalled-bus requests must not touch RAM.
        if0.hwdata = 32'hFFFFFFFF;
        req0(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10);
        tick();
        chk("busy_ready", 32'(if0.hreadyout), 32'h1);
        req0(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
        tick();
        chk("unsel_ready", 32'(if0.hreadyout), 32'h1);
        hold0 = 1'b1;
        req0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
        tick();
        chk("hold_ready", 32'(if0.hreadyout), 32'h1);
        hold0 = 1'b0;
        req0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        req0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        tick();
        chk("no_access_data", if0.hrdata, 32'h55663344);
        req0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        tick();

        // Write one word past the end of the array.
        req0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(DEPTH * 4));
        tick();
`ifdef AHB_RAM_ERR_CHECK_EN
        chk("oob_err1_ready", 32'(if0.hreadyout), 32'h0);
        chk("oob_err1_resp", 32'(if0.hresp), 32'h1);
        if0.hwdata = 32'h01020304;
        req0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        chk("oob_err2_ready", 32'(if0.hreadyout), 32'h1);
        chk("oob_err2_resp", 32'(if0.hresp), 32'h1);
        tick();
        chk("oob_done_resp", 32'(if0.hresp), 32'h0);
        req0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        chk("oob_ram_kept", if0.hrdata, 32'hCAFEF00D);
        req0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h1);
        tick();
        chk("misalign_err1_ready", 32'(if0.hreadyout), 32'h0);
        chk("misalign_err1_resp", 32'(if0.hresp), 32'h1);
        req0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        chk("misalign_err2_resp", 32'(if0.hresp), 32'h1);
        tick();
        req0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        chk("misalign_ram_kept", if0.hrdata, 32'hCAFEF00D);
`else
        chk("oob_wrap_ready", 32'(if0.hreadyout), 32'h1);
        chk("oob_wrap_resp", 32'(if0.hresp), 32'h0);
        if0.hwdata = 32'h01020304;
        req0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        chk("oob_wrap_data", if0.hrdata, 32'h01020304);
        chk("oob_wrap_rd_resp", 32'(if0.hresp), 32'h0);
`endif
        req0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        tick();

        // Three wait states on write and read.
        req3(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
        tick();
        req3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        if3.hwdata = 32'h0BADF00D;
        n = 0;
        while (if3.hreadyout !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("ws3_wr_wait", 32'(n), 32'd3);
        req3(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20);
        tick();
        req3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        n = 0;
        while (if3.hreadyout !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("ws3_rd_wait", 32'(n), 32'd3);
        chk("ws3_rd_data", if3.hrdata, 32'h0BADF00D);
        chk("ws3_rd_resp", 32'(if3.hresp), 32'h0);
        tick();

        // Reset in the middle of a write's wait states drops the write.
        req3(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
        tick();
        req3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        if3.hwdata = 32'h12345678;
        tick();
        chk("midwr_ready", 32'(if3.hreadyout), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(if3.hreadyout), 32'h1);
        chk("midrst_resp", 32'(if3.hresp), 32'h0);
        chk("midrst_hrdata", if3.hrdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        req3(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20);
        tick();
        req3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        n = 0;
        while (if3.hreadyout !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("midrst_rd_wait", 32'(n), 32'd3);
        chk("midrst_word_kept", if3.hrdata, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
